// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared definitions for the general-purpose register file:
//               default geometry, address/data typedefs and the index of the
//               hardwired zero register.
// Ports       : none (package)
// Options     : REGISTERS_BYPASS_EN is consumed by regfile_read_port; nothing
//               in this package depends on it.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  // Default geometry: 32 registers of 32 bits.
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 5;

  typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0] reg_data_t;

  // Index of the register that is hardwired to zero.
  localparam int unsigned ZERO_REG = 0;

  // True when an address selects the hardwired zero register.
  function automatic logic is_zero_reg(input reg_addr_t addr);
    return (addr == reg_addr_t'(ZERO_REG));
  endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
// Module      : regfile_read_port
// Description : One combinational read port of the register file. Selects the
//               addressed entry from the storage array, forces the zero
//               register to read 0 and, when REGISTERS_BYPASS_EN is defined,
//               forwards the data being written this cycle to a matching
//               read address.
// Ports       : i_regs      - full storage array (read only)
//               i_rd_addr   - read index
//               o_rd_data   - read data (zero-cycle latency)
//               i_rst_n     - active-low reset (bypass is suppressed in reset)
//               i_wr_en     - write enable of the write port
//               i_wr_addr   - write index
//               i_wr_data   - write data
// Options     : REGISTERS_BYPASS_EN - enable write-through forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = regfile_pkg::DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = regfile_pkg::DEF_ADDR_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] i_regs [0:(1 << ADDR_WIDTH)-1],
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  input  logic                  i_rst_n,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data
);

  localparam logic [ADDR_WIDTH-1:0] C_ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

  logic w_addr_is_zero;
  assign w_addr_is_zero = (i_rd_addr == C_ZERO_ADDR);

`ifdef REGISTERS_BYPASS_EN
  // Forward only a write that will actually commit at the next edge.
  logic w_bypass_hit;
  assign w_bypass_hit = i_rst_n && i_wr_en && (i_wr_addr == i_rd_addr);
`else
  logic unused_bypass;
  assign unused_bypass = ^{i_rst_n, i_wr_en, i_wr_addr, i_wr_data};
`endif

  always_comb begin
    o_rd_data = i_regs[i_rd_addr];
`ifdef REGISTERS_BYPASS_EN
    if (w_bypass_hit) begin
      o_rd_data = i_wr_data;
    end
`endif
    // Applied last so neither storage nor forwarding can leak through index 0.
    if (w_addr_is_zero) begin
      o_rd_data = '0;
    end
  end

endmodule : regfile_read_port
`default_nettype wire

// File: rtl/registers.sv
`default_nettype none
// ============================================================================
// Module      : registers
// Description : 2**ADDR_WIDTH x DATA_WIDTH general-purpose register file with
//               two combinational read ports and one synchronous write port.
//               Register 0 is hardwired to zero.
// Ports       : Clk             - clock, all updates on the rising edge
//               Reset_N         - synchronous active-low reset (wins over write)
//               Read_Register_1 - read index, port 1
//               Read_Register_2 - read index, port 2
//               Write_Register  - write index
//               Write_Data      - write data
//               Sig_Reg_Write   - write enable, active high
//               Read_Data_1     - read data, port 1
//               Read_Data_2     - read data, port 2
// Options     : REGISTERS_BYPASS_EN - write-through forwarding on both ports.
// Revision    : 1.0 - initial release
// ============================================================================
module registers
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = regfile_pkg::DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = regfile_pkg::DEF_ADDR_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Reset_N,
  input  logic [ADDR_WIDTH-1:0] Read_Register_1,
  input  logic [ADDR_WIDTH-1:0] Read_Register_2,
  input  logic [ADDR_WIDTH-1:0] Write_Register,
  input  logic [DATA_WIDTH-1:0] Write_Data,
  input  logic                  Sig_Reg_Write,
  output logic [DATA_WIDTH-1:0] Read_Data_1,
  output logic [DATA_WIDTH-1:0] Read_Data_2
);

  localparam int unsigned           C_NUM_REGS  = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] C_ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] regs_q [0:C_NUM_REGS-1];
  logic [DATA_WIDTH-1:0] regs_d [0:C_NUM_REGS-1];

  logic w_write_ok;
  assign w_write_ok = Sig_Reg_Write && (Write_Register != C_ZERO_ADDR);

  // Next-state: at most one entry changes per cycle; entry 0 stays zero so
  // the zero register never holds anything but 0.
  always_comb begin
    regs_d = regs_q;
    if (w_write_ok) begin
      regs_d[Write_Register] = Write_Data;
    end
    regs_d[ZERO_REG] = '0;
  end

  generate
    for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_entry
      always_ff @(posedge Clk) begin
        if (!Reset_N) begin
          regs_q[i] <= '0;
        end else begin
          regs_q[i] <= regs_d[i];
        end
      end
    end
  endgenerate

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_read_port_1 (
    .i_regs    (regs_q),
    .i_rd_addr (Read_Register_1),
    .o_rd_data (Read_Data_1),
    .i_rst_n   (Reset_N),
    .i_wr_en   (Sig_Reg_Write),
    .i_wr_addr (Write_Register),
    .i_wr_data (Write_Data)
  );

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_read_port_2 (
    .i_regs    (regs_q),
    .i_rd_addr (Read_Register_2),
    .o_rd_data (Read_Data_2),
    .i_rst_n   (Reset_N),
    .i_wr_en   (Sig_Reg_Write),
    .i_wr_addr (Write_Register),
    .i_wr_data (Write_Data)
  );

endmodule : registers
`default_nettype wire

// File: tb/tb_registers.sv
`default_nettype none
// ============================================================================
// Module      : tb_registers
// Description : Self-checking bench for the register file. Each step drives
//               one cycle of inputs on the falling edge, queues the expected
//               read data and compares it just before the next rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_registers;

`ifdef REGISTERS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [4:0]  ra1, ra2, wa;
  logic [31:0] wd;
  logic        we;
  logic [31:0] rd1, rd2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst_n;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        chk;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  typedef struct {
    int          tag;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t sb [$];
  vec_t tbl [15];

  registers #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .Clk             (clk),
    .Reset_N         (rst_n),
    .Read_Register_1 (ra1),
    .Read_Register_2 (ra2),
    .Write_Register  (wa),
    .Write_Data      (wd),
    .Sig_Reg_Write   (we),
    .Read_Data_1     (rd1),
    .Read_Data_2     (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic w, input logic [4:0] a,
                              input logic [31:0] d, input logic [4:0] p1,
                              input logic [4:0] p2, input logic c,
                              input logic [31:0] x1, input logic [31:0] x2);
    vec_t v;
    v.rst_n = r; v.we = w; v.wa = a; v.wd = d;
    v.ra1 = p1; v.ra2 = p2; v.chk = c; v.e1 = x1; v.e2 = x2;
    return v;
  endfunction

  // Drive one cycle; optionally check read data 1 time unit before the edge.
  task automatic step(input vec_t v, input int tag);
    exp_t e;
    @(negedge clk);
    rst_n = v.rst_n; we = v.we; wa = v.wa; wd = v.wd; ra1 = v.ra1; ra2 = v.ra2;
    if (v.chk) begin
      e.tag = tag; e.e1 = v.e1; e.e2 = v.e2;
      sb.push_back(e);
    end
    #4;
    if (v.chk) begin
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL scoreboard_empty step %0d", tag);
      end else begin
        e = sb.pop_front();
        checks++;
        if (rd1 !== e.e1) begin
          errors++;
          $display("FAIL step %0d port1 addr %0d got %h expected %h", e.tag, v.ra1, rd1, e.e1);
        end
        checks++;
        if (rd2 !== e.e2) begin
          errors++;
          $display("FAIL step %0d port2 addr %0d got %h expected %h", e.tag, v.ra2, rd2, e.e2);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;

    // Reset for 2 edges (second with a competing write), then basic traffic.
    tbl[0]  = mk(0, 0, 5'd0, 32'h0,        5'd0,  5'd0, 0, 32'h0, 32'h0);
    tbl[1]  = mk(0, 1, 5'd3, 32'hFFFF_FFFF, 5'd3, 5'd0, 0, 32'h0, 32'h0);
    tbl[2]  = mk(1, 0, 5'd0, 32'h0,        5'd0,  5'd5, 1, 32'h0, 32'h0);
    tbl[3]  = mk(1, 0, 5'd0, 32'h0,        5'd31, 5'd3, 1, 32'h0, 32'h0);
    tbl[4]  = mk(1, 1, 5'd3, 32'd20,       5'd3,  5'd4, 1, BYP ? 32'd20 : 32'd0, 32'h0);
    tbl[5]  = mk(1, 0, 5'd3, 32'd20,       5'd3,  5'd4, 1, 32'd20, 32'h0);
    tbl[6]  = mk(1, 1, 5'd0, 32'd10,       5'd0,  5'd3, 1, 32'h0, 32'd20);
    tbl[7]  = mk(1, 0, 5'd0, 32'd10,       5'd0,  5'd3, 1, 32'h0, 32'd20);
    tbl[8]  = mk(1, 0, 5'd3, 32'hDEAD_BEEF, 5'd3, 5'd3, 1, 32'd20, 32'd20);
    tbl[9]  = mk(1, 0, 5'd3, 32'hDEAD_BEEF, 5'd3, 5'd3, 1, 32'd20, 32'd20);
    tbl[10] = mk(1, 0, 5'd0, 32'h0,        5'd3,  5'd0, 1, 32'd20, 32'h0);
    tbl[11] = mk(1, 1, 5'd7, 32'h1234_5678, 5'd7, 5'd3, 1,
                 BYP ? 32'h1234_5678 : 32'h0, 32'd20);
    tbl[12] = mk(1, 0, 5'd0, 32'h0,        5'd7,  5'd7, 1, 32'h1234_5678, 32'h1234_5678);
    // Reset with a write pending: no forwarding, old contents until the edge.
    tbl[13] = mk(0, 1, 5'd7, 32'hAAAA_AAAA, 5'd7, 5'd3, 1, 32'h1234_5678, 32'd20);
    tbl[14] = mk(1, 0, 5'd0, 32'h0,        5'd7,  5'd3, 1, 32'h0, 32'h0);

    for (int i = 0; i < 15; i++) begin
      step(tbl[i], i);
    end

    // Sweep: write i*3 to every register, reading the same index meanwhile.
    for (int i = 1; i < 32; i++) begin
      step(mk(1, 1, 5'(i), 32'(i * 3), 5'(i), 5'(i), 1,
              BYP ? 32'(i * 3) : 32'h0, BYP ? 32'(i * 3) : 32'h0), 100 + i);
    end
    for (int i = 0; i < 32; i++) begin
      logic [4:0] j;
      j = 5'(31 - i);
      step(mk(1, 0, 5'd0, 32'h0, 5'(i), j, 1,
              32'(i * 3), 32'(j * 3)), 200 + i);
    end

    // Reset while writing all-ones to reg 9: bypass suppressed, then all zero.
    step(mk(0, 1, 5'd9, 32'hFFFF_FFFF, 5'd9, 5'd30, 1, 32'd27, 32'd90), 300);
    for (int i = 0; i < 32; i++) begin
      step(mk(1, 0, 5'd9, 32'hFFFF_FFFF, 5'(i), 5'(31 - i), 1, 32'h0, 32'h0), 400 + i);
    end

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d entries expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_registers
`default_nettype wire

// File: doc/registers.md
Name: registers

Overview:
- 32-entry x 32-bit general-purpose register file for the 32-bit RISC datapath, located between decode and the ALU/writeback stages.
- Two combinational read ports supply the ALU operands.
- One synchronous write port is driven by writeback.
- Register 0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32: width of each register and of the data ports.
- ADDR_WIDTH, 5: register index width. Number of registers = 2**ADDR_WIDTH.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset_N  input  1  synchronous, active-low reset, sampled on the rising edge of Clk.
- Read_Register_1  input  ADDR_WIDTH  index for read port 1.
- Read_Register_2  input  ADDR_WIDTH  index for read port 2.
- Write_Register  input  ADDR_WIDTH  index for the write port.
- Write_Data  input  DATA_WIDTH  data to write.
- Sig_Reg_Write  input  1  write enable, active high.
- Read_Data_1  output  DATA_WIDTH  contents of Read_Register_1.
- Read_Data_2  output  DATA_WIDTH  contents of Read_Register_2.

Behaviour:
- Interface: one clock (Clk); reset is synchronous and active-low (Reset_N).
- Reset: on a rising edge of Clk with Reset_N=0, all registers are cleared to 0. Reset has priority over a simultaneous write.
- After reset, Read_Data_1 and Read_Data_2 read 0 for every index.
- Write: on a rising edge of Clk with Reset_N=1, Sig_Reg_Write=1 and Write_Register!=0, the register at Write_Register takes Write_Data. It is visible on the read ports immediately after that edge.
- Writes with Sig_Reg_Write=0 are ignored.
- Writes to index 0 are discarded. Register 0 always reads 0.
- Read: purely combinational, with zero-cycle latency from address change to data.
- Both ports may address the same register and both return the same value.
- Read-during-write (same index, same cycle, feature off): the read returns the old value until the clock edge.
- X or undriven read addresses produce don't-care data. No X propagates into stored state.
- No handshake and no stall. One write per cycle at most.

Optional Feature:
- Macro: REGISTERS_BYPASS_EN.
- Defined: write-through forwarding. When Sig_Reg_Write=1, Write_Register!=0 and Read_Register_n==Write_Register, Read_Data_n returns Write_Data combinationally in the same cycle, before the edge.
- Forwarding is suppressed while Reset_N=0 and for index 0.
- Not defined: reads return stored contents only, as described in Behaviour.

Decomposition:
- Shared package regfile_pkg holds:
  - DATA_WIDTH and ADDR_WIDTH defaults.
  - a reg_addr_t typedef (logic [ADDR_WIDTH-1:0]).
  - a reg_data_t typedef (logic [DATA_WIDTH-1:0]).
  - a ZERO_REG constant (0).
- One sub-module is natural: regfile_read_port. It is instantiated twice and contains the address mux, the register-0 zeroing and the optional bypass compare.
- Storage and write logic stay in registers.

Test Plan:
- Reset: hold Reset_N=0 for 2 edges, then read indices 0, 5 and 31 -> all read 0x00000000.
- Basic write and read: write 20 to reg 3 (Sig_Reg_Write=1, one edge), then set Sig_Reg_Write=0 and read ports (3, 4) -> Read_Data_1=20, Read_Data_2=0.
- Zero register: write 10 to reg 0, then read ports (0, 3) -> Read_Data_1=0, Read_Data_2=20.
- Write-enable gating: Sig_Reg_Write=0 with Write_Register=3 and Write_Data=0xDEADBEEF over 2 edges -> reg 3 still reads 20.
- Read-during-write: write 0x12345678 to reg 7 while reading reg 7.
  - Without REGISTERS_BYPASS_EN: old value 0 before the edge, 0x12345678 after.
  - With REGISTERS_BYPASS_EN: 0x12345678 before the edge.
- Reset priority and full sweep:
  - Write i*3 to regs 1..31 -> readback matches on both ports.
  - Assert Reset_N=0 while Sig_Reg_Write=1 and Write_Data=0xFFFFFFFF -> after the edge, all registers read 0.
